// File: rtl/ps2_scancode_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_rx
// Description : PS/2 keyboard receiver. Synchronizes the device clock/data
//               lines, deframes 11-bit frames (start, 8 data LSB first, odd
//               parity, stop), and folds the 0xE0 / 0xF0 prefixes into
//               is_extended / is_break flags on a single key event.
//               Optional mid-frame watchdog enabled by macro PS2_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_DATA   = 2'd1;
    localparam logic [1:0] c_S_PARITY = 2'd2;
    localparam logic [1:0] c_S_STOP   = 2'd3;

    localparam logic [7:0] c_BREAK_PFX = 8'hF0;
    localparam logic [7:0] c_EXT_PFX   = 8'hE0;

    logic       r_clk_s1, r_clk_s2, r_clk_prev;
    logic       r_dat_s1, r_dat_s2;
    logic [1:0] r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_par;
    logic       r_brk_p, r_ext_p;

    logic       w_fall;
    logic       w_start_err;
    logic       w_frame_end;
    logic       w_par_ok;
    logic       w_good;
    logic       w_err;
    logic       w_timeout;

    // Two-flop synchronizers plus a history flop on the clock for edge detect;
    // all reset high because an idle PS/2 bus floats high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall   = r_clk_prev & ~r_clk_s2;
    // Odd parity: the nine bits together must hold an odd number of ones.
    assign w_par_ok = ^{r_shreg, r_par};

`ifdef PS2_TIMEOUT_EN
    localparam int              c_TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Watchdog: counts idle clk cycles between PS/2 edges while mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_S_IDLE) || w_fall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A real edge in the expiry cycle wins over the watchdog.
    assign w_timeout = (r_state != c_S_IDLE) && !w_fall && (r_to_cnt == c_TO_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state and start/stop classification.
    always_comb begin
        w_state_nxt = r_state;
        w_start_err = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_fall) begin
                    if (!r_dat_s2) w_state_nxt = c_S_DATA;
                    else           w_start_err = 1'b1;
                end
            end
            c_S_DATA: begin
                if (w_fall && (r_bit_cnt == 3'd7)) w_state_nxt = c_S_PARITY;
            end
            c_S_PARITY: begin
                if (w_fall) w_state_nxt = c_S_STOP;
            end
            c_S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = c_S_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = c_S_IDLE;
    end

    assign w_good = w_frame_end & r_dat_s2 & w_par_ok;
    assign w_err  = w_start_err | (w_frame_end & ~(r_dat_s2 & w_par_ok)) | w_timeout;

    // Bit counter, LSB-first shift register and parity capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'h00;
            r_par     <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                c_S_IDLE:   r_bit_cnt <= 3'd0;
                c_S_DATA: begin
                    r_shreg   <= {r_dat_s2, r_shreg[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                c_S_PARITY: r_par <= r_dat_s2;
                default:    ;
            endcase
        end
    end

    // Prefix resolution and registered event / error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_code   <= 8'h00;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
            r_brk_p     <= 1'b0;
            r_ext_p     <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (w_good) begin
                if (r_shreg == c_BREAK_PFX) begin
                    r_brk_p <= 1'b1;
                end else if (r_shreg == c_EXT_PFX) begin
                    r_ext_p <= 1'b1;
                end else begin
                    scan_code   <= r_shreg;
                    is_break    <= r_brk_p;
                    is_extended <= r_ext_p;
                    code_valid  <= 1'b1;
                    r_brk_p     <= 1'b0;
                    r_ext_p     <= 1'b0;
                end
            end else if (w_err) begin
                // Drop any half-received prefix sequence.
                frame_err <= 1'b1;
                r_brk_p   <= 1'b0;
                r_ext_p   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
